// File: rtl/memory_game_pkg.sv
// Shared constants, FSM state encoding and move-pulse payload for the memory game controller.
package memory_game_pkg;

    localparam int unsigned ROWS    = 4;
    localparam int unsigned COLS    = 10;
    localparam int unsigned N_CARDS = ROWS * COLS;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned N_PAIRS = 20;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned SCORE_W = 5;
    localparam int unsigned MOVES_W = 8;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        RD_A,
        RD_B,
        CMP,
        EVAL,
        SHOW,
        DONE
    } state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } move_t;

    function automatic logic is_busy(input state_t s);
        return (s == RD_A) || (s == RD_B) || (s == CMP) || (s == EVAL) || (s == SHOW);
    endfunction

endpackage

// File: rtl/memory_game_ctrl_grid_cursor.sv
// Row/column cursor over the card grid with independent wrap, fixed move priority and a sync clear.
module grid_cursor
    import memory_game_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  move_t            mv,
    output logic [IDX_W-1:0] index
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    // Only the highest-priority pulse is applied: up > down > left > right.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (mv.up) begin
                row_d = (row_q == '0) ? ROW_W'(ROWS - 1) : row_q - ROW_W'(1);
            end else if (mv.down) begin
                row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            end else if (mv.left) begin
                col_d = (col_q == '0) ? COL_W'(COLS - 1) : col_q - COL_W'(1);
            end else if (mv.right) begin
                col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            index <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            index <= IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);
        end
    end

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game sequencer: cursor, flip/compare of two cards, mismatch show timer, score and moves.
// Optional FAST_FLIP_EN: a select during the mismatch display ends it immediately.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned FACE_W      = 5,
    parameter int unsigned SHOW_CYCLES = 50_000_000
) (
    input  logic               CLK,
    input  logic               RST_BTN,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_sel,
    output logic [IDX_W-1:0]   face_addr,
    input  logic [FACE_W-1:0]  face_data,
    output logic [IDX_W-1:0]   cursor,
    output logic [N_CARDS-1:0] face_up,
    output logic [N_CARDS-1:0] matched,
    output logic [SCORE_W-1:0] score,
    output logic [MOVES_W-1:0] moves,
    output logic               game_done,
    output logic               busy
);

    localparam int unsigned TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   first_q, first_d;
    logic [IDX_W-1:0]   second_q, second_d;
    logic [FACE_W-1:0]  val_a_q, val_a_d;
    logic [FACE_W-1:0]  val_b_q, val_b_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   face_addr_d;
    logic [N_CARDS-1:0] face_up_d, matched_d;
    logic [SCORE_W-1:0] score_d;
    logic [MOVES_W-1:0] moves_d;
    logic               cursor_en, cursor_clr;
    logic               sel_ok, pair_eq, show_end;
    move_t              mv;

    assign mv      = '{up: btn_up, down: btn_down, left: btn_left, right: btn_right};
    assign sel_ok  = btn_sel && !face_up[cursor] && !matched[cursor];
    assign pair_eq = (val_a_q == val_b_q);

`ifdef FAST_FLIP_EN
    assign show_end = (timer_q == '0) || btn_sel;
`else
    assign show_end = (timer_q == '0);
`endif

    grid_cursor u_cursor (
        .clk   (CLK),
        .rst_n (RST_BTN),
        .en    (cursor_en),
        .clr   (cursor_clr),
        .mv    (mv),
        .index (cursor)
    );

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) state_q <= PICK1;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PICK1:   if (sel_ok) state_d = PICK2;
            PICK2:   if (sel_ok) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = CMP;
            CMP:     state_d = EVAL;
            EVAL: begin
                if (pair_eq) state_d = (score == SCORE_W'(N_PAIRS - 1)) ? DONE : PICK1;
                else         state_d = SHOW;
            end
            SHOW:    if (show_end) state_d = PICK1;
            DONE:    if (btn_sel) state_d = PICK1;
            default: state_d = PICK1;
        endcase
    end

    // Next values for all datapath registers; everything holds unless the state acts on it.
    always_comb begin
        first_d     = first_q;
        second_d    = second_q;
        val_a_d     = val_a_q;
        val_b_d     = val_b_q;
        timer_d     = timer_q;
        face_addr_d = face_addr;
        face_up_d   = face_up;
        matched_d   = matched;
        score_d     = score;
        moves_d     = moves;
        cursor_en   = (state_q != DONE);
        cursor_clr  = 1'b0;
        case (state_q)
            PICK1: begin
                if (sel_ok) begin
                    first_d           = cursor;
                    face_up_d[cursor] = 1'b1;
                end
            end
            PICK2: begin
                if (sel_ok) begin
                    second_d          = cursor;
                    face_up_d[cursor] = 1'b1;
                    moves_d           = (moves == '1) ? moves : moves + MOVES_W'(1);
                    face_addr_d       = first_q;
                end
            end
            RD_A:  face_addr_d = second_q;
            RD_B:  val_a_d = face_data;
            CMP:   val_b_d = face_data;
            EVAL: begin
                if (pair_eq) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    face_up_d[first_q]  = 1'b0;
                    face_up_d[second_q] = 1'b0;
                    score_d             = score + SCORE_W'(1);
                end else begin
                    timer_d = TMR_W'(SHOW_CYCLES - 1);
                end
            end
            SHOW: begin
                if (show_end) begin
                    face_up_d[first_q]  = 1'b0;
                    face_up_d[second_q] = 1'b0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DONE: begin
                if (btn_sel) begin
                    face_up_d  = '0;
                    matched_d  = '0;
                    score_d    = '0;
                    moves_d    = '0;
                    cursor_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            first_q   <= '0;
            second_q  <= '0;
            val_a_q   <= '0;
            val_b_q   <= '0;
            timer_q   <= '0;
            face_addr <= '0;
            face_up   <= '0;
            matched   <= '0;
            score     <= '0;
            moves     <= '0;
            game_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            first_q   <= first_d;
            second_q  <= second_d;
            val_a_q   <= val_a_d;
            val_b_q   <= val_b_d;
            timer_q   <= timer_d;
            face_addr <= face_addr_d;
            face_up   <= face_up_d;
            matched   <= matched_d;
            score     <= score_d;
            moves     <= moves_d;
            game_done <= (state_d == DONE);
            busy      <= is_busy(state_d);
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Randomized bench for memory_game_ctrl against a timeline-based model of the game rules.
module tb_memory_game_ctrl;

    localparam int SHOW = 8;
`ifdef FAST_FLIP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_BTN;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [5:0]  face_addr;
    logic [4:0]  face_data;
    logic [5:0]  cursor;
    logic [39:0] face_up, matched;
    logic [4:0]  score;
    logic [7:0]  moves;
    logic        game_done, busy;

    memory_game_ctrl #(.FACE_W(5), .SHOW_CYCLES(SHOW)) dut (
        .CLK       (CLK),
        .RST_BTN   (RST_BTN),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_sel   (btn_sel),
        .face_addr (face_addr),
        .face_data (face_data),
        .cursor    (cursor),
        .face_up   (face_up),
        .matched   (matched),
        .score     (score),
        .moves     (moves),
        .game_done (game_done),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Game model: cursor as row/col, masks as bit arrays, pending compare/hide as absolute edge numbers
    int        face_tbl[40];
    int        m_row, m_col, m_score, m_moves, m_addr, m_first, m_second;
    bit [39:0] m_up, m_match;
    bit        m_done;
    int        cyc, resolve_at, hide_at;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int m_cursor();
        return m_row * 10 + m_col;
    endfunction

    function automatic int partner(input int i);
        for (int j = 0; j < 40; j++)
            if (j != i && face_tbl[j] == face_tbl[i]) return j;
        return i;
    endfunction

    task automatic model_reset();
        m_row = 0; m_col = 0; m_score = 0; m_moves = 0; m_addr = 0;
        m_up = '0; m_match = '0; m_done = 1'b0;
        m_first = -1; m_second = -1; resolve_at = -1; hide_at = -1;
    endtask

    task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit s);
        int cur;
        cur = m_cursor();
        if (m_done) begin
            if (s) begin
                m_up = '0; m_match = '0; m_score = 0; m_moves = 0;
                m_row = 0; m_col = 0; m_done = 1'b0; m_first = -1;
            end
        end else begin
            if (u)      m_row = (m_row + 3) % 4;
            else if (d) m_row = (m_row + 1) % 4;
            else if (l) m_col = (m_col + 9) % 10;
            else if (r) m_col = (m_col + 1) % 10;
            if (resolve_at == cyc) begin
                resolve_at = -1;
                if (face_tbl[m_first] == face_tbl[m_second]) begin
                    m_match[m_first] = 1'b1; m_match[m_second] = 1'b1;
                    m_up[m_first] = 1'b0; m_up[m_second] = 1'b0;
                    m_score++;
                    m_first = -1;
                    if (m_score == 20) m_done = 1'b1;
                end else begin
                    hide_at = cyc + SHOW;
                end
            end else if (hide_at >= 0) begin
                if (hide_at == cyc || (FAST && s)) begin
                    m_up[m_first] = 1'b0; m_up[m_second] = 1'b0;
                    hide_at = -1; m_first = -1;
                end
            end else if (resolve_at < 0 && s && !m_up[cur] && !m_match[cur]) begin
                m_up[cur] = 1'b1;
                if (m_first < 0) begin
                    m_first = cur;
                end else begin
                    m_second = cur;
                    if (m_moves < 255) m_moves++;
                    resolve_at = cyc + 4;
                    m_addr = m_first;
                end
            end
            if (resolve_at == cyc + 3) m_addr = m_second;
        end
    endtask

    task automatic check_all();
        check("cursor", cursor, m_cursor());
        check("face_up", face_up, m_up);
        check("matched", matched, m_match);
        check("score", score, m_score);
        check("moves", moves, m_moves);
        check("game_done", game_done, m_done);
        check("busy", busy, (resolve_at >= 0 || hide_at >= 0));
        check("face_addr", face_addr, m_addr);
    endtask

    task automatic cycle(input bit u, input bit d, input bit l, input bit r, input bit s);
        logic [5:0] a;
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        a = face_addr;
        @(posedge CLK);
        #1;
        face_data = 5'(face_tbl[a]);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
        cyc++;
        model_step(u, d, l, r, s);
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic sel();
        cycle(0, 0, 0, 0, 1);
    endtask

    task automatic goto_card(input int target);
        int n;
        n = 0;
        while (m_cursor() != target && !m_done && n < 100) begin
            if (m_row != target / 10) cycle(0, 1, 0, 0, 0);
            else                      cycle(0, 0, 0, 1, 0);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            idle();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pool[$];
        int fixed_v[4];
        int n, j, tmp, other;

        fixed_v = '{7, 7, 4, 9};
        for (int v = 0; v < 20; v++) begin
            pool.push_back(v);
            pool.push_back(v);
        end
        for (int k = 0; k < 4; k++) begin
            face_tbl[k] = fixed_v[k];
            for (int p = 0; p < pool.size(); p++)
                if (pool[p] == fixed_v[k]) begin
                    pool.delete(p);
                    break;
                end
        end
        for (int i = pool.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
        end
        for (int k = 0; k < 36; k++) face_tbl[4 + k] = pool[k];

        cyc = 0;
        RST_BTN = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
        face_data = '0;
        model_reset();
        #1 RST_BTN = 1'b0;
        #10;
        check_all();
        #11 RST_BTN = 1'b1;

        // Cursor movement and wrap
        cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        check("cursor_13", cursor, 6'd13);
        cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);
        check("cursor_33", cursor, 6'd33);
        cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("cursor_wrap_left", cursor, 6'd39);
        cycle(1, 1, 1, 1, 0);
        check("cursor_priority", cursor, 6'd29);

        // Matching pair 0/1
        goto_card(0); sel();
        goto_card(1); sel();
        n = 0;
        while (!matched[1] && n < 20) begin idle(); n++; end
        check("eval_latency", n, 4);
        check("match_mask", matched[1:0], 2'b11);
        check("match_score", score, 5'd1);
        check("match_moves", moves, 8'd1);

        // Mismatching pair 2/3
        goto_card(2); sel();
        goto_card(3); sel();
        n = 0;
        while (face_up[3:2] == 2'b11 && n < 40) begin idle(); n++; end
        check("show_len", n, 4 + SHOW);
        check("mismatch_score", score, 5'd1);
        check("mismatch_moves", moves, 8'd2);

        // Ignored selects
        goto_card(4); sel();
        sel();
        check("reselect_moves", moves, 8'd2);
        goto_card(0); sel();
        check("sel_matched", face_up, 40'h10);
        goto_card(5); sel();
        cycle(0, 0, 0, 1, 0);
        sel();
        check("sel_busy", face_up[6], 1'b0);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tmp = $urandom_range(15, 0);
            cycle(tmp[0], tmp[1] & ($urandom_range(1, 0) == 1), tmp[2], tmp[3],
                  $urandom_range(3, 0) == 0);
        end

        // Finish the game
        wait_idle();
        if (m_first >= 0 && !m_done) begin
            goto_card(partner(m_first)); sel(); wait_idle();
        end
        for (int i = 0; i < 40; i++) begin
            if (!m_match[i] && !m_done) begin
                goto_card(i); sel();
                goto_card(partner(i)); sel();
                wait_idle();
            end
        end
        check("score_full", score, 5'd20);
        check("game_done", game_done, 1'b1);
        cycle(0, 0, 0, 1, 0);
        sel();
        check("restart_cursor", cursor, 6'd0);
        check("restart_matched", matched, 40'd0);
        check("restart_score", score, 5'd0);
        check("restart_moves", moves, 8'd0);
        check("restart_done", game_done, 1'b0);

        // Reset during SHOW
        other = 1;
        while (face_tbl[other] == face_tbl[0]) other++;
        goto_card(0); sel();
        goto_card(other); sel();
        for (int i = 0; i < 6; i++) idle();
        #2 RST_BTN = 1'b0;
        #1;
        model_reset();
        check("rst_face_up", face_up, 40'd0);
        check("rst_cursor", cursor, 6'd0);
        check("rst_moves", moves, 8'd0);
        check("rst_busy", busy, 1'b0);
        check_all();
        @(negedge CLK);
        RST_BTN = 1'b1;
        cycle(0, 0, 0, 1, 0);
        sel();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
